alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, multi-cycle successor to the team's 8-bit combinational ALU. It uses the same 3-bit opcode map and adds the following:
- registered valid/ready handshakes on input and output;
- iterative WIDTH-cycle multiply and divide, returning the full double-width product and the remainder;
- an explicit divide-by-zero flag.

It sits between the control unit and the register file and executes one operation at a time.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 4..32.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  operand/opcode bundle valid.
in_ready  out  1  block can accept a bundle; high only in IDLE.
opcode  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 DIV, 111 EQ.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
out_valid  out  1  result bundle valid.
out_ready  in  1  consumer accepts result.
result  out  WIDTH  primary result (MUL low half, DIV quotient).
result_hi  out  WIDTH  MUL high half, DIV remainder, 0 for all other ops.
carry  out  1  ADD carry-out; SUB borrow (a<b); MUL = |result_hi; DIV = divide-by-zero; otherwise 0.
div_by_zero  out  1  DIV issued with b==0.

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset (async, rst_n=0):
  - state = IDLE; out_valid, result, result_hi, carry, div_by_zero and counter = 0.
  - in_ready = 1 after release.
  - A reset during BUSY or DONE aborts the operation and drops the result.
- Accept: when in_valid && in_ready on a clock edge, latch opcode, a and b.
  - Inputs are ignored while in_ready = 0.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, EQ, and DIV with b==0): IDLE -> DONE.
  - out_valid rises 1 cycle after the accept edge.
- MUL/DIV (b!=0): IDLE -> BUSY with counter = WIDTH.
  - One shift-add (MUL) or restoring-subtract (DIV) step per cycle; counter decrements.
  - BUSY -> DONE when counter reaches 1.
  - out_valid rises exactly WIDTH+1 cycles after the accept edge.
- DONE: out_valid = 1; result, result_hi, carry and div_by_zero held stable until out_ready = 1.
  - On out_valid && out_ready: DONE -> IDLE, out_valid = 0 next cycle, outputs keep their last value.
  - Next accept is possible no earlier than the cycle after the return to IDLE; there is no overlap.
- Arithmetic:
  - ADD/SUB are computed at WIDTH+1 bits, modulo 2^WIDTH.
  - EQ gives result = 1 if a==b, else 0.
  - MUL is unsigned; {result_hi, result} = a*b.
  - DIV is unsigned; result = a/b, result_hi = a%b.
- Divide by zero: result = 0, result_hi = a, carry = 1, div_by_zero = 1; completes in single-cycle latency.
- div_by_zero = 0 for all other ops.

Optional Feature:
Macro ALU_FLAGS_EN.
- Defined: adds outputs zero_flag (result==0 && result_hi==0) and neg_flag (result[WIDTH-1]).
  - Both are registered alongside result, valid under the same out_valid, and reset to 0.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic[2:0] opcode_e (OP_ADD..OP_EQ);
  - typedef enum state_e (S_IDLE, S_BUSY, S_DONE);
  - localparam DEFAULT_WIDTH = 8.
- One sub-module, alu_muldiv_iter, holds the WIDTH-step shift-add/restoring-divide datapath.
  - Inputs: start, is_div, a, b, step enable.
  - Outputs: lo, hi.
  - The top keeps the FSM, counter, handshake and single-cycle ops.

Test Plan:
WIDTH=8 unless noted.
1. ADD a=200, b=100, out_ready=1 -> result=0x2C, carry=1, result_hi=0, out_valid exactly 1 cycle after accept; SUB a=5, b=7 -> result=0xFE, carry=1.
2. MUL a=0xFF, b=0xFF -> result=0x01, result_hi=0xFE, carry=1, out_valid exactly 9 cycles after accept, in_ready=0 throughout.
3. DIV a=200, b=7 -> result=28, result_hi=4, div_by_zero=0, 9-cycle latency; DIV a=5, b=0 -> result=0, result_hi=5, carry=1, div_by_zero=1, 1-cycle latency.
4. Backpressure: XOR a=0xA5, b=0x0F with out_ready=0 for 5 cycles -> result=0xAA held stable, out_valid=1, in_ready=0, a new in_valid bundle is ignored; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
5. Reset mid-operation: rst_n=0 on cycle 4 of a MUL -> outputs 0 immediately (asynchronously); after release in_ready=1, and a following EQ a=9, b=9 returns result=1.
6. WIDTH=16 build with ALU_FLAGS_EN: MUL a=0x0100, b=0x0100 -> result=0, result_hi=0x0001, zero_flag=0, latency 17 cycles; SUB a=3, b=3 -> zero_flag=1, neg_flag=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode and FSM state encodings for the sequential ALU.
package alu_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_MUL = 3'b101,
      OP_DIV = 3'b110,
      OP_EQ  = 3'b111
   } opcode_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-step unsigned shift-add multiplier and
// restoring divider. After WIDTH steps {hi, lo} holds a*b (MUL) or
// hi = a % b, lo = a / b (DIV). Pure datapath, so no reset.
module alu_muldiv_iter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             step,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   logic [WIDTH-1:0] b_q;
   logic             is_div_q;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;

   // Candidate next values for one multiply or divide step.
   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      div_shift = {hi, lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, b_q};
   end

   // Load operands on start, then advance one step per enabled cycle.
   // For DIV the quotient bits shift into lo as the dividend shifts out;
   // div_diff[WIDTH] set means the trial subtract underflowed.
   always_ff @(posedge clk) begin
      if (start) begin
         hi       <= '0;
         lo       <= a;
         b_q      <= b;
         is_div_q <= is_div;
      end else if (step) begin
         if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
               hi <= div_diff[WIDTH-1:0];
               lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
               hi <= div_shift[WIDTH-1:0];
               lo <= {lo[WIDTH-2:0], 1'b0};
            end
         end else begin
            {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshakes. Single-cycle ops
// complete one cycle after accept; MUL and DIV (b != 0) iterate WIDTH
// steps in alu_muldiv_iter. Optional macro ALU_FLAGS_EN adds registered
// zero_flag and neg_flag outputs.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             carry,
   output logic             div_by_zero
`ifdef ALU_FLAGS_EN
   ,
   output logic             zero_flag,
   output logic             neg_flag
`endif
);

   state_e           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   opcode_e          op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             accept;
   logic             iter_in;
   logic             capture;
   logic [WIDTH:0]   sum_w, diff_w;
   logic [WIDTH-1:0] it_lo, it_hi;
   logic [WIDTH-1:0] res_lo, res_hi;
   logic             res_c, res_dz;

   assign in_ready = (state == S_IDLE);
   assign accept   = in_valid && in_ready;
   assign iter_in  = (opcode == OP_MUL) || ((opcode == OP_DIV) && (b != '0));
   // Results are captured on the first DONE cycle, which is what makes
   // out_valid land one cycle after the state enters DONE.
   assign capture  = (state == S_DONE) && !out_valid;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = iter_in ? S_BUSY : S_DONE;
         S_BUSY: if (cnt == CNT_W'(1)) state_nxt = S_DONE;
         S_DONE: if (out_valid && out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Iteration counter: loaded with WIDTH on an iterative accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 cnt <= '0;
      else if (accept && iter_in) cnt <= CNT_W'(WIDTH);
      else if (state == S_BUSY)   cnt <= cnt - CNT_W'(1);
   end

   // Operand latch on accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q <= opcode_e'(opcode);
         a_q  <= a;
         b_q  <= b;
      end
   end

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .start  (accept && iter_in),
      .is_div (opcode == OP_DIV),
      .a      (a),
      .b      (b),
      .step   (state == S_BUSY),
      .lo     (it_lo),
      .hi     (it_hi)
   );

   // Result selection from latched operands or the iterative datapath.
   always_comb begin
      sum_w  = {1'b0, a_q} + {1'b0, b_q};
      diff_w = {1'b0, a_q} - {1'b0, b_q};
      res_lo = '0;
      res_hi = '0;
      res_c  = 1'b0;
      res_dz = 1'b0;
      case (op_q)
         OP_ADD: begin res_lo = sum_w[WIDTH-1:0];  res_c = sum_w[WIDTH];  end
         OP_SUB: begin res_lo = diff_w[WIDTH-1:0]; res_c = diff_w[WIDTH]; end
         OP_AND: res_lo = a_q & b_q;
         OP_OR:  res_lo = a_q | b_q;
         OP_XOR: res_lo = a_q ^ b_q;
         OP_EQ:  res_lo = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
         OP_MUL: begin res_lo = it_lo; res_hi = it_hi; res_c = |it_hi; end
         OP_DIV: begin
            if (b_q == '0) begin
               res_hi = a_q;
               res_c  = 1'b1;
               res_dz = 1'b1;
            end else begin
               res_lo = it_lo;
               res_hi = it_hi;
            end
         end
         default: res_lo = '0;
      endcase
   end

   // Output bundle: captured once in DONE, held until the consumer takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         result      <= '0;
         result_hi   <= '0;
         carry       <= 1'b0;
         div_by_zero <= 1'b0;
`ifdef ALU_FLAGS_EN
         zero_flag   <= 1'b0;
         neg_flag    <= 1'b0;
`endif
      end else if (capture) begin
         out_valid   <= 1'b1;
         result      <= res_lo;
         result_hi   <= res_hi;
         carry       <= res_c;
         div_by_zero <= res_dz;
`ifdef ALU_FLAGS_EN
         zero_flag   <= (res_lo == '0) && (res_hi == '0);
         neg_flag    <= res_lo[WIDTH-1];
`endif
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed tests for alu_seq at WIDTH=8 and WIDTH=16.
// Flag outputs are exercised when built with ALU_FLAGS_EN.
module tb_alu_seq;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // WIDTH=8 instance signals
   logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [2:0] opcode = 3'd0;
   logic [7:0] a = 8'd0, b = 8'd0, result, result_hi;
   logic       carry, div_by_zero;
   // WIDTH=16 instance signals
   logic        w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ready = 1'b0;
   logic [2:0]  w_opcode = 3'd0;
   logic [15:0] w_a = 16'd0, w_b = 16'd0, w_result, w_result_hi;
   logic        w_carry, w_div_by_zero;
`ifdef ALU_FLAGS_EN
   logic zero_flag, neg_flag, w_zero_flag, w_neg_flag;
`endif

   alu_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result_hi(result_hi), .carry(carry), .div_by_zero(div_by_zero)
`ifdef ALU_FLAGS_EN
      , .zero_flag(zero_flag), .neg_flag(neg_flag)
`endif
   );

   alu_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
      .opcode(w_opcode), .a(w_a), .b(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready),
      .result(w_result), .result_hi(w_result_hi), .carry(w_carry), .div_by_zero(w_div_by_zero)
`ifdef ALU_FLAGS_EN
      , .zero_flag(w_zero_flag), .neg_flag(w_neg_flag)
`endif
   );

   // Present one bundle to dut8, return cycles from accept edge to out_valid
   // (-1 on timeout) and whether in_ready was seen high while waiting.
   task automatic issue8(input logic [2:0] op, input logic [7:0] aa, input logic [7:0] bb,
                         output int lat, output bit rdy_seen);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      opcode = op; a = aa; b = bb; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      lat = -1; rdy_seen = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         if (i > 1) begin @(posedge clk); #1; end
         else begin @(posedge clk); #1; end
         if (out_valid) begin lat = i; break; end
         if (in_ready) rdy_seen = 1'b1;
      end
   endtask

   task automatic issue16(input logic [2:0] op, input logic [15:0] aa, input logic [15:0] bb,
                          output int lat);
      int n = 0;
      @(negedge clk);
      while (!w_in_ready && n < 50) begin @(negedge clk); n++; end
      w_opcode = op; w_a = aa; w_b = bb; w_in_valid = 1'b1;
      @(posedge clk); #1 w_in_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (w_out_valid) begin lat = i; break; end
      end
   endtask

   // Consume the dut8 result and confirm return to IDLE.
   task automatic finish8(input string name);
      out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_release got out_valid=%b in_ready=%b exp 0 1", name, out_valid, in_ready);
      end
   endtask

   task automatic finish16();
      w_out_ready = 1'b1;
      @(posedge clk); #1 w_out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || result !== 8'h00 || result_hi !== 8'h00 ||
          carry !== 1'b0 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b r=%h hi=%h c=%b dz=%b exp all 0",
                  out_valid, result, result_hi, carry, div_by_zero);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b exp 1", in_ready);
      end
   endtask

   task automatic test_addsub();
      int lat; bit rs;
      issue8(3'b000, 8'd200, 8'd100, lat, rs);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d exp 1", lat); end
      checks++;
      if (result !== 8'h2C || carry !== 1'b1 || result_hi !== 8'h00 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL add_result got r=%h c=%b hi=%h dz=%b exp 2c 1 00 0", result, carry, result_hi, div_by_zero);
      end
      finish8("add");
      issue8(3'b001, 8'd5, 8'd7, lat, rs);
      checks++;
      if (lat !== 1 || result !== 8'hFE || carry !== 1'b1) begin
         errors++;
         $display("FAIL sub_result got lat=%0d r=%h c=%b exp 1 fe 1", lat, result, carry);
      end
      finish8("sub");
   endtask

   task automatic test_logic();
      int lat; bit rs;
      issue8(3'b010, 8'hF0, 8'h3C, lat, rs);
      checks++;
      if (result !== 8'h30 || carry !== 1'b0) begin
         errors++; $display("FAIL and_result got r=%h c=%b exp 30 0", result, carry);
      end
      finish8("and");
      issue8(3'b011, 8'hF0, 8'h3C, lat, rs);
      checks++;
      if (result !== 8'hFC) begin errors++; $display("FAIL or_result got %h exp fc", result); end
      finish8("or");
      issue8(3'b111, 8'd9, 8'd8, lat, rs);
      checks++;
      if (result !== 8'h00 || lat !== 1) begin
         errors++; $display("FAIL eq_ne_result got r=%h lat=%0d exp 00 1", result, lat);
      end
      finish8("eq_ne");
   endtask

   task automatic test_mul();
      int lat; bit rs;
      issue8(3'b101, 8'hFF, 8'hFF, lat, rs);
      checks++;
      if (lat !== 9) begin errors++; $display("FAIL mul_latency got %0d exp 9", lat); end
      checks++;
      if (rs !== 1'b0) begin errors++; $display("FAIL mul_in_ready_busy got %b exp 0", rs); end
      checks++;
      if (result !== 8'h01 || result_hi !== 8'hFE || carry !== 1'b1 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL mul_result got r=%h hi=%h c=%b dz=%b exp 01 fe 1 0", result, result_hi, carry, div_by_zero);
      end
      finish8("mul");
   endtask

   task automatic test_div();
      int lat; bit rs;
      issue8(3'b110, 8'd200, 8'd7, lat, rs);
      checks++;
      if (lat !== 9) begin errors++; $display("FAIL div_latency got %0d exp 9", lat); end
      checks++;
      if (result !== 8'd28 || result_hi !== 8'd4 || div_by_zero !== 1'b0 || carry !== 1'b0) begin
         errors++;
         $display("FAIL div_result got q=%0d r=%0d dz=%b c=%b exp 28 4 0 0", result, result_hi, div_by_zero, carry);
      end
      finish8("div");
      issue8(3'b110, 8'd5, 8'd0, lat, rs);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL div0_latency got %0d exp 1", lat); end
      checks++;
      if (result !== 8'd0 || result_hi !== 8'd5 || carry !== 1'b1 || div_by_zero !== 1'b1) begin
         errors++;
         $display("FAIL div0_result got q=%0d r=%0d c=%b dz=%b exp 0 5 1 1", result, result_hi, carry, div_by_zero);
      end
      finish8("div0");
   endtask

   task automatic test_backpressure();
      int lat; bit rs;
      issue8(3'b100, 8'hA5, 8'h0F, lat, rs);
      @(negedge clk);
      opcode = 3'b000; a = 8'h01; b = 8'h01; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (result !== 8'hAA || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold_%0d got r=%h v=%b rdy=%b exp aa 1 0", i, result, out_valid, in_ready);
         end
      end
      in_valid = 1'b0;
      finish8("bp");
      checks++;
      if (result !== 8'hAA) begin errors++; $display("FAIL bp_keep_result got %h exp aa", result); end
      // A bundle offered during DONE must not have been taken.
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_ignored_bundle got v=%b rdy=%b exp 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_op();
      int lat; bit rs;
      @(negedge clk);
      opcode = 3'b101; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (result !== 8'h00 || result_hi !== 8'h00 || carry !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_outputs got r=%h hi=%h c=%b v=%b exp 00 00 0 0", result, result_hi, carry, out_valid);
      end
      @(negedge clk) rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b exp 1", in_ready); end
      issue8(3'b111, 8'd9, 8'd9, lat, rs);
      checks++;
      if (result !== 8'h01 || lat !== 1) begin
         errors++; $display("FAIL rstmid_eq got r=%h lat=%0d exp 01 1", result, lat);
      end
      finish8("rstmid_eq");
   endtask

   task automatic test_w16();
      int lat;
      issue16(3'b101, 16'h0100, 16'h0100, lat);
      checks++;
      if (lat !== 17) begin errors++; $display("FAIL w16_mul_latency got %0d exp 17", lat); end
      checks++;
      if (w_result !== 16'h0000 || w_result_hi !== 16'h0001 || w_carry !== 1'b1) begin
         errors++;
         $display("FAIL w16_mul_result got r=%h hi=%h c=%b exp 0000 0001 1", w_result, w_result_hi, w_carry);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if (w_zero_flag !== 1'b0) begin errors++; $display("FAIL w16_mul_zero_flag got %b exp 0", w_zero_flag); end
`endif
      finish16();
      issue16(3'b001, 16'd3, 16'd3, lat);
      checks++;
      if (w_result !== 16'h0000 || w_carry !== 1'b0 || lat !== 1) begin
         errors++; $display("FAIL w16_sub_result got r=%h c=%b lat=%0d exp 0000 0 1", w_result, w_carry, lat);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if (w_zero_flag !== 1'b1 || w_neg_flag !== 1'b0) begin
         errors++; $display("FAIL w16_sub_flags got z=%b n=%b exp 1 0", w_zero_flag, w_neg_flag);
      end
`endif
      finish16();
   endtask

   initial begin
      test_reset();
      test_addsub();
      test_logic();
      test_mul();
      test_div();
      test_backpressure();
      test_reset_mid_op();
      test_w16();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard bound on run time.
   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end

endmodule
